psum_requant: RTL and testbench

- Downstream stage of the PE MAC array.
- Accepts a stream of signed partial sums from one PE output lane and accumulates one output pixel's group of partials, starting from a per-group bias.
- On the group's last beat it requantizes the sum to int8 (rounding right shift, optional ReLU, saturation).
- Presents the int8 result to the OFM writer over a valid/ready handshake.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/requant_round_sat.sv | 43 ++++
 rtl/psum_requant.sv | 120 ++++++++++++
 tb/tb_psum_requant.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, FSM states and int8 bounds for the CNN datapath
package cnn_pkg;

   localparam int DEF_PSUM_W  = 16;
   localparam int DEF_ACC_W   = 32;
   localparam int DEF_OUT_W   = 8;
   localparam int DEF_SHIFT_W = 5;

   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   typedef enum logic [1:0] {
      S_ACC = 2'd0,
      S_RQ  = 2'd1,
      S_OUT = 2'd2
   } state_t;

endpackage

// File: rtl/requant_round_sat.sv
// rtl/requant_round_sat.sv - combinational rounding shift, optional ReLU and output clamp
module requant_round_sat
   import cnn_pkg::*;
#(
   parameter int ACC_W   = DEF_ACC_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int SHIFT_W = DEF_SHIFT_W
) (
   input  logic signed [ACC_W-1:0]   acc,
   input  logic        [SHIFT_W-1:0] shift,
   input  logic                      relu_en,
   output logic signed [OUT_W-1:0]   data
);

   // Output range bounds; with OUT_W=8 these equal INT8_MAX / INT8_MIN.
   localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
   localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W-1)));

   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] r;

   // One extra bit keeps acc + half-LSB from wrapping before the arithmetic shift.
   always_comb begin
      ext  = {acc[ACC_W-1], acc};
      rnd  = '0;
      if (shift != '0) begin
         rnd = (ACC_W+1)'(1) <<< (shift - SHIFT_W'(1));
      end
      r = (ext + rnd) >>> shift;
      if (relu_en && (r < 0)) begin
         r = '0;
      end
      if (r > OUT_MAX) begin
         data = OUT_MAX[OUT_W-1:0];
      end else if (r < OUT_MIN) begin
         data = OUT_MIN[OUT_W-1:0];
      end else begin
         data = r[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - partial-sum group accumulator with int8 requantization and output handshake
module psum_requant
   import cnn_pkg::*;
#(
   parameter int PSUM_W  = DEF_PSUM_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int SHIFT_W = DEF_SHIFT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               psum_valid,
   output logic               psum_ready,
   input  logic [PSUM_W-1:0]  psum_data,
   input  logic               psum_last,
   input  logic [ACC_W-1:0]   bias,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               relu_en,
   output logic               ofm_valid,
   input  logic               ofm_ready,
   output logic [OUT_W-1:0]   ofm_data,
   output logic               acc_ovf
);

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t             state;
   state_t             state_nxt;
   logic [ACC_W-1:0]   acc;
   logic               first;
   logic [ACC_W-1:0]   base;
   logic [ACC_W:0]     sum;
   logic               sum_ovf;
   logic [ACC_W-1:0]   sum_sat;
   logic               beat;
   logic [OUT_W-1:0]   rq_data;

   // Handshake flags are pure decodes of the state register.
   assign psum_ready = (state == S_ACC);
   assign ofm_valid  = (state == S_OUT);
   assign beat       = psum_valid & psum_ready;

   // Saturating accumulate: the top two bits of the widened sum disagree on overflow.
   always_comb begin
      base    = first ? bias : acc;
      sum     = {base[ACC_W-1], base} + {{(ACC_W+1-PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
      sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
      if (sum_ovf) begin
         sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         sum_sat = sum[ACC_W-1:0];
      end
   end

   requant_round_sat #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
   ) u_rq (
      .acc     (acc),
      .shift   (shift),
      .relu_en (relu_en),
      .data    (rq_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accumulate until the last beat, requantize for one cycle, hold until taken.
   always_comb begin
      state_nxt = state;
      case (state)
         S_ACC:   if (beat && psum_last) state_nxt = S_RQ;
         S_RQ:    state_nxt = S_OUT;
         S_OUT:   if (ofm_ready) state_nxt = S_ACC;
         default: state_nxt = S_ACC;
      endcase
   end

   // Accumulator, group-start flag, result register and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         first    <= 1'b1;
         ofm_data <= '0;
         acc_ovf  <= 1'b0;
      end else begin
         case (state)
            S_ACC: begin
               if (beat) begin
                  acc   <= sum_sat;
                  first <= 1'b0;
                  if (sum_ovf) begin
                     acc_ovf <= 1'b1;
                  end
               end
            end
            S_RQ: begin
               ofm_data <= rq_data;
            end
            S_OUT: begin
               if (ofm_ready) begin
                  first <= 1'b1;
               end
            end
            default: begin
               first <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_requant.sv
// tb/tb_psum_requant.sv - self-checking bench for psum_requant
module tb_psum_requant;

   logic        clk;
   logic        reset;
   logic        psum_valid;
   logic        psum_ready;
   logic [15:0] psum_data;
   logic        psum_last;
   logic [31:0] bias;
   logic [4:0]  shift;
   logic        relu_en;
   logic        ofm_valid;
   logic        ofm_ready;
   logic [7:0]  ofm_data;
   logic        acc_ovf;

   int n_tests = 0;
   int n_fail  = 0;
   bit mdl_ovf = 1'b0;

   typedef struct packed {
      logic signed [31:0] b;
      logic [2:0]         n;
      logic [3:0][15:0]   p;
      logic [4:0]         sh;
      logic               rl;
      logic [3:0]         hold;
      logic signed [7:0]  exp_d;
      logic               exp_ovf;
   } vec_t;

   vec_t vecs[11];

   psum_requant dut (
      .clk        (clk),
      .reset      (reset),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready),
      .psum_data  (psum_data),
      .psum_last  (psum_last),
      .bias       (bias),
      .shift      (shift),
      .relu_en    (relu_en),
      .ofm_valid  (ofm_valid),
      .ofm_ready  (ofm_ready),
      .ofm_data   (ofm_data),
      .acc_ovf    (acc_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input int b, input int n, input int p0, input int p1, input int p2,
                               input int sh, input int rl, input int hold, input int ed, input int eo);
      vec_t v;
      v.b       = b;
      v.n       = 3'(n);
      v.p[0]    = 16'(p0);
      v.p[1]    = 16'(p1);
      v.p[2]    = 16'(p2);
      v.p[3]    = 16'(0);
      v.sh      = 5'(sh);
      v.rl      = 1'(rl);
      v.hold    = 4'(hold);
      v.exp_d   = 8'(ed);
      v.exp_ovf = 1'(eo);
      return v;
   endfunction

   // Reference: integer sum with int32 clamp, floor((x + 2^(s-1)) / 2^s), ReLU, int8 clamp.
   function automatic int model(input longint b, input int n, input logic [3:0][15:0] p,
                                input int sh, input bit rl);
      longint a;
      longint num;
      longint d;
      longint q;
      a = b;
      for (int i = 0; i < n; i++) begin
         a = a + longint'($signed(p[i]));
         if (a > 64'sd2147483647) begin
            a = 64'sd2147483647;
            mdl_ovf = 1'b1;
         end else if (a < -64'sd2147483648) begin
            a = -64'sd2147483648;
            mdl_ovf = 1'b1;
         end
      end
      if (sh == 0) begin
         q = a;
      end else begin
         d   = longint'(1) << sh;
         num = a + d / 2;
         q   = num / d;
         if ((num % d != 0) && (num < 0)) q = q - 1;
      end
      if (rl && q < 0) q = 0;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return int'(q);
   endfunction

   task automatic run_group(input logic signed [31:0] b, input int n, input logic [3:0][15:0] p,
                            input int sh, input bit rl, input int hold,
                            output logic signed [7:0] got_d, output logic got_ovf);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("beat_psum_ready", longint'(psum_ready), 1);
         psum_valid = 1'b1;
         psum_data  = p[i];
         psum_last  = (i == n - 1);
         bias       = (i == 0) ? b : $urandom;
         shift      = 5'($urandom_range(0, 30));
         relu_en    = 1'($urandom_range(0, 1));
         ofm_ready  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      psum_valid = 1'b0;
      psum_last  = 1'b0;
      bias       = $urandom;
      shift      = 5'(sh);
      relu_en    = rl;
      chk("rq_ofm_valid", longint'(ofm_valid), 0);
      chk("rq_psum_ready", longint'(psum_ready), 0);
      @(negedge clk);
      chk("latency_ofm_valid", longint'(ofm_valid), 1);
      shift   = 5'($urandom_range(0, 30));
      relu_en = 1'($urandom_range(0, 1));
      got_d   = ofm_data;
      got_ovf = acc_ovf;
      for (int h = 0; h < hold; h++) begin
         ofm_ready  = 1'b0;
         psum_valid = 1'b1;
         psum_data  = 16'($urandom);
         psum_last  = 1'b1;
         @(negedge clk);
         chk("hold_ofm_valid", longint'(ofm_valid), 1);
         chk("hold_ofm_data", longint'($signed(ofm_data)), longint'(got_d));
         chk("hold_psum_ready", longint'(psum_ready), 0);
      end
      ofm_ready = 1'b1;
      @(negedge clk);
      psum_valid = 1'b0;
      psum_last  = 1'b0;
      ofm_ready  = 1'b0;
      chk("post_ofm_valid", longint'(ofm_valid), 0);
      chk("post_psum_ready", longint'(psum_ready), 1);
   endtask

   initial begin
      logic signed [7:0] gd;
      logic              go;
      logic [3:0][15:0]  rp;
      logic signed [31:0] rb;
      int                rn;
      int                rs;
      bit                rr;
      int                exp_d;

      vecs[0]  = mk(10, 3, 5, -3, 20, 2, 0, 0, 8, 0);
      vecs[1]  = mk(0, 1, 6, 0, 0, 2, 0, 0, 2, 0);
      vecs[2]  = mk(0, 1, -6, 0, 0, 2, 0, 0, -1, 0);
      vecs[3]  = mk(0, 1, 5, 0, 0, 2, 0, 0, 1, 0);
      vecs[4]  = mk(-100, 1, 4, 0, 0, 0, 1, 0, 0, 0);
      vecs[5]  = mk(-100, 1, 4, 0, 0, 0, 0, 0, -96, 0);
      vecs[6]  = mk(0, 1, 1000, 0, 0, 2, 0, 0, 127, 0);
      vecs[7]  = mk(0, 1, -1000, 0, 0, 2, 0, 0, -128, 0);
      vecs[8]  = mk(3, 2, -7, 100, 0, 1, 0, 5, 48, 0);
      vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
      vecs[10] = mk(32'h7FFFFFF0, 2, 32767, 32767, 0, 0, 0, 0, 127, 1);

      reset      = 1'b1;
      psum_valid = 1'b0;
      psum_data  = '0;
      psum_last  = 1'b0;
      bias       = '0;
      shift      = '0;
      relu_en    = 1'b0;
      ofm_ready  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset_psum_ready", longint'(psum_ready), 1);
      chk("reset_ofm_valid", longint'(ofm_valid), 0);
      chk("reset_ofm_data", longint'(ofm_data), 0);
      chk("reset_acc_ovf", longint'(acc_ovf), 0);

      for (int i = 0; i < 11; i++) begin
         run_group(vecs[i].b, int'(vecs[i].n), vecs[i].p, int'(vecs[i].sh), vecs[i].rl,
                   int'(vecs[i].hold), gd, go);
         chk($sformatf("vec%0d_ofm_data", i), longint'(gd), longint'(vecs[i].exp_d));
         chk($sformatf("vec%0d_acc_ovf", i), longint'(go), longint'(vecs[i].exp_ovf));
      end

      // Reset in the middle of a group discards the partial sum and the sticky flag.
      @(negedge clk);
      psum_valid = 1'b1;
      bias       = 32'd50;
      psum_data  = 16'd7;
      psum_last  = 1'b0;
      @(negedge clk);
      psum_valid = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_ofm_valid", longint'(ofm_valid), 0);
      chk("midreset_acc_ovf", longint'(acc_ovf), 0);
      chk("midreset_psum_ready", longint'(psum_ready), 1);
      chk("midreset_ofm_data", longint'(ofm_data), 0);
      rp = '0;
      rp[0] = 16'd3;
      run_group(32'sd0, 1, rp, 0, 1'b0, 0, gd, go);
      chk("midreset_next_data", longint'(gd), 3);
      chk("midreset_next_ovf", longint'(go), 0);

      mdl_ovf = 1'b0;
      for (int g = 0; g < 60; g++) begin
         rn = $urandom_range(1, 4);
         for (int k = 0; k < 4; k++) rp[k] = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rb = $urandom;
         else rb = 32'($signed($urandom_range(0, 10000)) - 5000);
         if ($urandom_range(0, 3) == 0) rs = $urandom_range(0, 30);
         else rs = $urandom_range(0, 8);
         rr = 1'($urandom_range(0, 1));
         exp_d = model(longint'(rb), rn, rp, rs, rr);
         run_group(rb, rn, rp, rs, rr, $urandom_range(0, 2), gd, go);
         chk($sformatf("rand%0d_ofm_data", g), longint'(gd), longint'(exp_d));
         chk($sformatf("rand%0d_acc_ovf", g), longint'(go), longint'(mdl_ovf));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
